// File: rtl/inter_pred_chroma_pipe.sv
// Three-stage stallable chroma bilinear interpolator: weights -> products -> round/shift.
// Optional bi-prediction averaging of pass-0/pass-1 beats under `CHROMA_BIPRED_AVG_EN.
module inter_pred_chroma_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int FRAC_BITS = 3,
  parameter int LANES     = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FRAC_BITS-1:0]           in_xfrac,
  input  logic [FRAC_BITS-1:0]           in_yfrac,
  input  logic [(LANES+1)*BIT_DEPTH-1:0] in_row0,
  input  logic [(LANES+1)*BIT_DEPTH-1:0] in_row1,
  input  logic                           in_bipred,
  input  logic                           in_pass,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*BIT_DEPTH-1:0]     out_pix,
  output logic                           out_err
);
  localparam int S     = 1 << FRAC_BITS;
  localparam int WW    = 2 * FRAC_BITS + 1;
  localparam int PW    = BIT_DEPTH + WW;
  localparam int SH    = 2 * FRAC_BITS;
  localparam int ROW_W = (LANES + 1) * BIT_DEPTH;
  localparam int PIX_W = LANES * BIT_DEPTH;

  // Valid/ready: a beat moves on clk when valid && ready; the whole pipe
  // freezes while the output beat is offered but refused (no skid buffer).
  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  logic [WW-1:0] xf, yf, xi, yi;
  logic [WW-1:0] w_in [4];
  assign xf = WW'(in_xfrac);
  assign yf = WW'(in_yfrac);
  assign xi = WW'(S) - xf;
  assign yi = WW'(S) - yf;
  assign w_in[0] = xi * yi;
  assign w_in[1] = xf * yi;
  assign w_in[2] = xi * yf;
  assign w_in[3] = xf * yf;

  logic             s1_valid, s1_bip, s1_pass;
  logic [WW-1:0]    s1_w [4];
  logic [ROW_W-1:0] s1_row0, s1_row1;
  logic             s2_valid, s2_bip, s2_pass;
  logic [PW-1:0]    s2_prod [LANES][4];
  logic             s3_valid, s3_bip, s3_pass;
  logic [PIX_W-1:0] s3_pix;

  logic [PW-1:0]    prod [LANES][4];
  logic [PIX_W-1:0] pix_next;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      prod[j][0] = PW'(s1_w[0]) * PW'(s1_row0[j*BIT_DEPTH +: BIT_DEPTH]);
      prod[j][1] = PW'(s1_w[1]) * PW'(s1_row0[(j+1)*BIT_DEPTH +: BIT_DEPTH]);
      prod[j][2] = PW'(s1_w[2]) * PW'(s1_row1[j*BIT_DEPTH +: BIT_DEPTH]);
      prod[j][3] = PW'(s1_w[3]) * PW'(s1_row1[(j+1)*BIT_DEPTH +: BIT_DEPTH]);
    end
  end

  // The weights sum to S*S, so the rounded sum never exceeds the largest sample.
  always_comb begin
    pix_next = '0;
    for (int j = 0; j < LANES; j++) begin
      logic [PW-1:0] acc;
      acc = s2_prod[j][0] + s2_prod[j][1] + s2_prod[j][2] + s2_prod[j][3]
            + PW'(1 << (SH - 1));
      pix_next[j*BIT_DEPTH +: BIT_DEPTH] = acc[SH +: BIT_DEPTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0; s1_bip <= 1'b0; s1_pass <= 1'b0;
      s1_row0  <= '0;   s1_row1 <= '0;
      for (int k = 0; k < 4; k++) s1_w[k] <= '0;
      s2_valid <= 1'b0; s2_bip <= 1'b0; s2_pass <= 1'b0;
      for (int j = 0; j < LANES; j++)
        for (int k = 0; k < 4; k++) s2_prod[j][k] <= '0;
      s3_valid <= 1'b0; s3_bip <= 1'b0; s3_pass <= 1'b0;
      s3_pix   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_bip   <= in_bipred;
      s1_pass  <= in_pass;
      s1_row0  <= in_row0;
      s1_row1  <= in_row1;
      for (int k = 0; k < 4; k++) s1_w[k] <= w_in[k];
      s2_valid <= s1_valid;
      s2_bip   <= s1_bip;
      s2_pass  <= s1_pass;
      s2_prod  <= prod;
      s3_valid <= s2_valid;
      s3_bip   <= s2_bip;
      s3_pass  <= s2_pass;
      s3_pix   <= pix_next;
    end
  end

`ifdef CHROMA_BIPRED_AVG_EN
  logic [PIX_W-1:0] hold;
  logic             hold_valid;
  logic             s3_first, s3_second;
  logic [PIX_W-1:0] avg_pix;

  assign s3_first  = s3_valid && s3_bip && !s3_pass;
  assign s3_second = s3_valid && s3_bip && s3_pass;
  // A pass-0 bipred beat is never offered downstream, so it cannot stall.
  assign out_valid = s3_valid && !s3_first;
  assign out_err   = s3_second && !hold_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (s3_first) begin
      hold       <= s3_pix;
      hold_valid <= 1'b1;
    end else if (s3_second && out_ready) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    avg_pix = '0;
    for (int j = 0; j < LANES; j++) begin
      logic [BIT_DEPTH:0] t;
      t = {1'b0, hold[j*BIT_DEPTH +: BIT_DEPTH]}
          + {1'b0, s3_pix[j*BIT_DEPTH +: BIT_DEPTH]} + 1'b1;
      avg_pix[j*BIT_DEPTH +: BIT_DEPTH] = t[BIT_DEPTH:1];
    end
  end

  assign out_pix = (s3_second && hold_valid) ? avg_pix : s3_pix;
`else
  logic unused_bipred;
  assign unused_bipred = ^{s3_bip, s3_pass};
  assign out_valid     = s3_valid;
  assign out_err       = 1'b0;
  assign out_pix       = s3_pix;
`endif

endmodule

// File: tb/tb_inter_pred_chroma_pipe.sv
// Bench for inter_pred_chroma_pipe: directed corner beats plus a random stream
// scored against an arithmetic model; bipred checks when CHROMA_BIPRED_AVG_EN is set.
module tb_inter_pred_chroma_pipe;
  localparam int BD = 8, F = 3, L = 4, S = 8;
  localparam int ROW_W = (L + 1) * BD, PIX_W = L * BD;

  logic             clk = 0, reset_n = 0;
  logic             in_valid = 0, in_ready, in_bipred = 0, in_pass = 0;
  logic [F-1:0]     in_xfrac = 0, in_yfrac = 0;
  logic [ROW_W-1:0] in_row0 = 0, in_row1 = 0;
  logic             out_valid, out_ready = 1, out_err;
  logic [PIX_W-1:0] out_pix;

  int tests = 0, fails = 0, hold_cnt = 0;
  bit rand_ready = 0;
  logic [PIX_W-1:0] exp_q[$];
  bit               err_q[$];
  logic [PIX_W-1:0] hold_m = 0, prev_pix = 0, mon_exp, mon_raw;
  bit               hold_mv = 0, prev_stall = 0, mon_err;

  inter_pred_chroma_pipe #(.BIT_DEPTH(BD), .FRAC_BITS(F), .LANES(L)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_xfrac(in_xfrac), .in_yfrac(in_yfrac), .in_row0(in_row0), .in_row1(in_row1),
    .in_bipred(in_bipred), .in_pass(in_pass), .out_valid(out_valid),
    .out_ready(out_ready), .out_pix(out_pix), .out_err(out_err));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: bilinear weights straight from the fractional offsets
  function automatic logic [PIX_W-1:0] model(int x, int y, logic [ROW_W-1:0] r0, logic [ROW_W-1:0] r1);
    logic [PIX_W-1:0] res;
    res = '0;
    for (int j = 0; j < L; j++) begin
      int a, b, c, d, s;
      a = int'(r0[j*BD +: BD]);     b = int'(r0[(j+1)*BD +: BD]);
      c = int'(r1[j*BD +: BD]);     d = int'(r1[(j+1)*BD +: BD]);
      s = ((S-x)*(S-y)*a + x*(S-y)*b + (S-x)*y*c + x*y*d + (1 << (2*F-1))) >> (2*F);
      res[j*BD +: BD] = BD'(s);
    end
    return res;
  endfunction

  function automatic logic [PIX_W-1:0] avg2(logic [PIX_W-1:0] p, logic [PIX_W-1:0] q);
    logic [PIX_W-1:0] res;
    res = '0;
    for (int j = 0; j < L; j++)
      res[j*BD +: BD] = BD'((int'(p[j*BD +: BD]) + int'(q[j*BD +: BD]) + 1) / 2);
    return res;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i <= L; i++) r[i*BD +: BD] = BD'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(int v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i <= L; i++) r[i*BD +: BD] = BD'(v);
    return r;
  endfunction

  function automatic bit pick();
    if (hold_cnt > 0) begin
      hold_cnt--;
      return 1'b0;
    end
    if (rand_ready) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // scoreboard: expectations are formed at acceptance, in order
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_pix_held", out_pix, prev_pix);
      end
      check("in_ready_rule", in_ready, (out_valid && !out_ready) ? 1'b0 : 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", out_valid, 0);
        else begin
          mon_exp = exp_q.pop_front();
          mon_err = err_q.pop_front();
          check("pix", out_pix, mon_exp);
          check("err", out_err, mon_err);
        end
      end
      if (in_valid && in_ready) begin
        mon_raw = model(int'(in_xfrac), int'(in_yfrac), in_row0, in_row1);
`ifdef CHROMA_BIPRED_AVG_EN
        if (in_bipred && !in_pass) begin
          hold_m = mon_raw; hold_mv = 1;
        end else if (in_bipred && in_pass) begin
          exp_q.push_back(hold_mv ? avg2(hold_m, mon_raw) : mon_raw);
          err_q.push_back(!hold_mv);
          hold_mv = 0;
        end else begin
          exp_q.push_back(mon_raw); err_q.push_back(0);
        end
`else
        exp_q.push_back(mon_raw); err_q.push_back(0);
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pix;
    end
  end

  // driver tasks
  task automatic send(input logic [F-1:0] x, input logic [F-1:0] y, input logic [ROW_W-1:0] r0,
                      input logic [ROW_W-1:0] r1, input bit bip, input bit pass);
    bit got;
    got = 0;
    in_valid = 1; in_xfrac = x; in_yfrac = y; in_row0 = r0; in_row1 = r1;
    in_bipred = bip; in_pass = pass;
    out_ready = pick();
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
      if (!got) out_ready = pick();
    end
    in_valid = 0;
    if (!got) check("accept_timeout", in_ready, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      out_ready = pick();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    rand_ready = 0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
    idle(3);
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  // After send returns: idle, idle, then the beat on the third cycle.
  task automatic lat_check(input string tag, input logic [PIX_W-1:0] mask,
                           input logic [PIX_W-1:0] exp, input bit exp_err);
    @(negedge clk); check({tag, "_c1_idle"}, out_valid, 0);
    @(negedge clk); check({tag, "_c2_idle"}, out_valid, 0);
    @(negedge clk); check({tag, "_c3_valid"}, out_valid, 1);
    check(tag, out_pix & mask, exp);
    check({tag, "_err"}, out_err, exp_err);
    @(posedge clk); #1;
  endtask

  logic [ROW_W-1:0] r0, r1;

  initial begin
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_err", out_err, 0);
    reset_n = 1;
    @(negedge clk); check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // exact copy at x=y=0
    r0 = rand_row(); r0[7:0] = 8'd100; r1 = rand_row();
    send(0, 0, r0, r1, 0, 0);
    lat_check("copy", 32'h0000_00FF, 32'd100, 0);
    drain();

    // half-pel
    r0 = rand_row(); r0[7:0] = 8'd0;  r0[15:8] = 8'd64;
    r1 = rand_row(); r1[7:0] = 8'd64; r1[15:8] = 8'd128;
    send(4, 4, r0, r1, 0, 0);
    lat_check("half_pel", 32'h0000_00FF, 32'd64, 0);
    drain();

    // saturation bound
    send(7, 7, fill_row(255), fill_row(255), 0, 0);
    lat_check("saturate", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drain();

    // back-pressure mid-stream
    for (int i = 0; i < 6; i++) begin
      if (i == 3) hold_cnt = 4;
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rand_row(), rand_row(), 0, 0);
    end
    drain();

    // random stream with random back-pressure and gaps
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rand_row(), rand_row(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    // reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rand_row(), rand_row(), 0, 0);
    reset_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pix", out_pix, 0);
    exp_q.delete(); err_q.delete(); hold_mv = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk); check("midrst_in_ready", in_ready, 1);
    idle(8);
    drain();

`ifdef CHROMA_BIPRED_AVG_EN
    // pass-0 100 then pass-1 51 -> one beat of 76
    send(0, 0, fill_row(100), rand_row(), 1, 0);
    send(0, 0, fill_row(51), rand_row(), 1, 1);
    lat_check("bipred_avg", 32'hFFFF_FFFF, 32'h4C4C_4C4C, 0);
    drain();
    // lone pass-1 -> unaveraged with error flag
    send(0, 0, fill_row(90), rand_row(), 1, 1);
    lat_check("bipred_lone", 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
